// File: rtl/shifter_arbiter_if.sv
// Bundle of the two requester channels and the result channel of the
// shared shifter. The slave side is the arbiter; the master side drives
// requests and consumes results.
interface shifter_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt;
  logic [1:0]  req0_alufn;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt;
  logic [1:0]  req1_alufn;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;

  modport slave (
    input  req0_valid, req0_a, req0_shamt, req0_alufn,
    input  req1_valid, req1_a, req1_shamt, req1_alufn,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id
  );

  modport master (
    output req0_valid, req0_a, req0_shamt, req0_alufn,
    output req1_valid, req1_a, req1_shamt, req1_alufn,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Two requesters share one barrel shifter. A one-entry result register
// sits behind the shifter; a requester is accepted only when that
// register is free or being drained in the same cycle. Contention is
// resolved round-robin (RR_EN=1) or with requester 0 always first.
module shifter_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input logic             clk,
  input logic             rst_n,
  shifter_arbiter_if.slave bus
);

  localparam bit ROUND_ROBIN = (RR_EN != 0);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        last_grant_reg;
  logic [31:0] out_data_reg;
  logic        out_id_reg;

  logic        out_valid_int;
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        xfer;

  logic [31:0] sel_a;
  logic [4:0]  sel_shamt;
  logic [1:0]  sel_alufn;

  logic        shift_left;
  logic        fill_bit;
  logic [31:0] a_rev;
  logic [31:0] stage_in;
  logic [31:0] right_result;
  logic [31:0] right_rev;
  logic [31:0] shift_result;

  assign out_valid_int = (state_reg == FULL);
  assign slot_free     = !out_valid_int || bus.out_ready;

  // Grant selection: a lone requester always wins; under contention the
  // requester that did not win the last transfer goes next (round-robin),
  // or requester 0 always wins (fixed priority).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (ROUND_ROBIN && !last_grant_reg) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Readies are held low during reset so nothing is accepted into a
  // register that is being cleared.
  assign bus.req0_ready = rst_n && grant0 && slot_free;
  assign bus.req1_ready = rst_n && grant1 && slot_free;

  assign xfer = (bus.req0_valid && bus.req0_ready) ||
                (bus.req1_valid && bus.req1_ready);

  // Steer the granted requester's operands into the shared datapath.
  always_comb begin
    if (grant1) begin
      sel_a     = bus.req1_a;
      sel_shamt = bus.req1_shamt;
      sel_alufn = bus.req1_alufn;
    end else begin
      sel_a     = bus.req0_a;
      sel_shamt = bus.req0_shamt;
      sel_alufn = bus.req0_alufn;
    end
  end

  // The shifter only shifts right. A left shift is done by bit-reversing
  // the operand, shifting right with zero fill, and reversing back.
  assign shift_left = (sel_alufn == 2'b00);
  assign fill_bit   = sel_alufn[1] & sel_a[31];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev
      assign a_rev[gi]     = sel_a[31 - gi];
      assign right_rev[gi] = right_result[31 - gi];
    end
  endgenerate

  assign stage_in = shift_left ? a_rev : sel_a;

  // Five log stages, stage gi shifting by 2**gi when shamt bit gi is set.
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [31:0] q;
      if (gi == 0) begin : g_first
        assign q = sel_shamt[gi] ? {{SH{fill_bit}}, stage_in[31:SH]} : stage_in;
      end else begin : g_next
        assign q = sel_shamt[gi] ? {{SH{fill_bit}}, g_stage[gi-1].q[31:SH]}
                                 : g_stage[gi-1].q;
      end
    end
  endgenerate

  assign right_result = g_stage[4].q;
  assign shift_result = shift_left ? right_rev : right_result;

  // Result-register occupancy: a transfer always leaves it full (a new
  // result may replace one drained in the same cycle); a drain with no
  // transfer empties it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (xfer) state_next = FULL;
      end
      FULL: begin
        if (xfer) begin
          state_next = FULL;
        end else if (bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Occupancy state register; reset discards any held result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the result and remember the winner only on an actual transfer,
  // so stalled contention never rotates priority. After reset requester 1
  // counts as the last winner, giving requester 0 the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= 32'h0;
      out_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (xfer) begin
      out_data_reg   <= shift_result;
      out_id_reg     <= grant1;
      last_grant_reg <= grant1;
    end
  end

  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;

endmodule

// File: doc/shifter_arbiter.md
SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, selects the arbitration policy: 1 = round-robin, 0 = fixed priority with requester 0 winning.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has a shift operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a  input  32  requester 0 operand.
REQ-007 req0_shamt  input  5  requester 0 shift amount.
REQ-008 req0_alufn  input  2  requester 0 shift select, as {funct7[5], funct3[2]}.
REQ-009 req1_valid, req1_ready, req1_a, req1_shamt, req1_alufn  same directions and widths as REQ-004..REQ-008, for requester 1.
REQ-010 out_valid  output  1  result register holds an undelivered result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  32  shifted result.
REQ-013 out_id  output  1  index of the requester that produced out_data.

Function
REQ-014 A single shared shift datapath SHALL serve both requesters: alufn[1]=1 gives an arithmetic right shift (sign-filled); alufn=2'b01 gives a logical right shift; alufn=2'b00 gives a logical left shift.
REQ-015 shamt SHALL be used as an unsigned 0..31 value; shamt=0 passes the operand through unchanged for all modes.
REQ-016 slot_free SHALL be defined as (!out_valid || out_ready).
REQ-017 Grant rule when only one reqN_valid is high: that requester is granted.
REQ-018 Grant rule when both are high and RR_EN=1: grant the requester that is not last_grant.
REQ-019 Grant rule when both are high and RR_EN=0: grant requester 0.
REQ-020 reqN_ready SHALL equal grantN && slot_free, combinationally; at most one ready SHALL be high per cycle.
REQ-021 ready SHALL NOT depend on its own requester's valid for the ungranted requester, i.e. the ungranted ready is 0.
REQ-022 A transfer occurs when reqN_valid && reqN_ready: on that edge, out_data <= shift(reqN operands), out_id <= N, out_valid <= 1, and last_grant <= N.
REQ-023 Latency SHALL be exactly 1 cycle from acceptance to out_valid.
REQ-024 Throughput SHALL be 1 result per cycle while out_ready is held high.
REQ-025 Two-state FSM:
- EMPTY (out_valid=0) -> FULL on transfer.
- FULL -> EMPTY on out_ready with no new transfer.
- FULL -> FULL on simultaneous out_ready and transfer (the new result replaces the old).
- FULL holds on !out_ready.
REQ-026 While FULL and !out_ready, out_data, out_id and out_valid SHALL remain stable, and both ready signals SHALL be 0.
REQ-027 last_grant SHALL change only on a transfer; contention with no slot free SHALL NOT rotate priority.
REQ-028 With RR_EN=1 and both requesters continuously valid, grants SHALL strictly alternate, so neither requester waits more than one transfer.
REQ-029 Operands SHALL be sampled only on the transfer edge; requester inputs are don't-care otherwise.

Reset
REQ-030 While rst_n=0: out_valid=0, out_data=32'h0, out_id=0, last_grant=1 (requester 0 wins the first contention), FSM=EMPTY.
REQ-031 Reset asserted mid-operation SHALL immediately drop out_valid and discard any held result with no delivery.
REQ-032 req0_ready and req1_ready SHALL be 0 while rst_n=0.
REQ-033 The first transfer SHALL be possible in the first clock edge after rst_n deasserts.

Verification
REQ-034 req0 SRA, a=32'h8000_0000, shamt=4, out_ready=1 -> next cycle out_valid=1, out_data=32'hF800_0000, out_id=0.
REQ-035 req1 SRL, a=32'h8000_0000, shamt=31, then SLL, a=32'h1, shamt=31 -> results 32'h0000_0001 then 32'h8000_0000, back-to-back, out_id=1.
REQ-036 Both valid for 4 cycles, RR_EN=1, out_ready=1 -> out_id sequence 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-037 out_ready=0 for 3 cycles after a result, both requesters valid -> both readies 0, out_data stable; on release, one transfer, and the next grant alternates from the last actual grant.
REQ-038 rst_n pulsed low while FULL -> out_valid drops asynchronously; after release, the first contention is granted to requester 0.
REQ-039 shamt=0 in each of the three modes with a=32'hDEAD_BEEF -> out_data=32'hDEAD_BEEF.
